// File: rtl/jpeg_dct_pkg.sv
// jpeg_dct_pkg: shared coefficient/internal types and the shift-add lifting multipliers
// used by both the forward DCT and the inverse.
package jpeg_dct_pkg;
    localparam int DCT_N     = 8;
    localparam int DCT_IN_W  = 16;
    localparam int DCT_INT_W = 18;

    typedef logic signed [DCT_IN_W-1:0]  dct_coef_t;
    typedef logic signed [DCT_INT_W-1:0] dct_int_t;

    function automatic dct_int_t k2(dct_int_t v);
        return (v >>> 3) + (v >>> 2);
    endfunction

    function automatic dct_int_t k3(dct_int_t v);
        return (v >>> 3) + (v >>> 1);
    endfunction

    function automatic dct_int_t k4(dct_int_t v);
        return (v >>> 3) + (v >>> 2) + (v >>> 1);
    endfunction
endpackage

// File: rtl/idct_stage_reg.sv
// idct_stage_reg: 8-lane pipeline register with valid bit, 3-bit row tag and stall enable.
module idct_stage_reg
    import jpeg_dct_pkg::*;
#(
    parameter int W = 18
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               valid_in,
    input  logic [2:0]         tag_in,
    input  logic [DCT_N*W-1:0] d,
    output logic               valid,
    output logic [2:0]         tag,
    output logic [DCT_N*W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            q     <= '0;
        end else if (en) begin
            valid <= valid_in;
            tag   <= tag_in;
            q     <= d;
        end
    end
endmodule

// File: rtl/idct_8pt_pipe.sv
// idct_8pt_pipe: 4-stage pipelined 8-point lifting IDCT with valid/ready and block row tagging.
// Define IDCT_CLAMP_EN to saturate outputs to [0, 2^OUT_W-1]; otherwise outputs are truncated signed.
module idct_8pt_pipe
    import jpeg_dct_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int INT_W = 18,
    parameter int OUT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DCT_N*IN_W-1:0] y_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DCT_N*16-1:0]   x_out,
    output logic                  out_last
);
    logic                   en;
    logic [2:0]             row;
    logic [DCT_N*INT_W-1:0] d1, q1, d2, q2, d3, q3;
    logic [DCT_N*16-1:0]    d4;
    logic                   v1, v2, v3, v4;
    logic [2:0]             t1, t2, t3, t4;
    dct_int_t               y[DCT_N], c[DCT_N], p[DCT_N], b[DCT_N];
    dct_int_t               s[DCT_N], a[DCT_N], u[DCT_N], r[DCT_N];

    function automatic logic [15:0] fmt(dct_int_t v);
`ifdef IDCT_CLAMP_EN
        return (v < 0) ? 16'd0 : (v > dct_int_t'((1 << OUT_W) - 1)) ? 16'((1 << OUT_W) - 1) : 16'(v);
`else
        return v[15:0];
`endif
    endfunction

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_ff @(posedge clk) begin
        if (!rst_n)
            row <= '0;
        else if (in_valid && en)
            row <= row + 3'd1;
    end

    // I1: undo forward stage 4
    always_comb begin
        for (int i = 0; i < DCT_N; i++) y[i] = dct_int_t'(dct_coef_t'(y_in[i*IN_W +: IN_W]));
        c[1] = (y[0] >>> 1) - y[1];
        c[0] = y[0] - c[1];
        c[3] = y[3] - k2(y[2]);
        c[2] = k2(c[3]) - y[2];
        c[4] = y[4] + (y[7] >>> 3);
        c[7] = y[7];
        c[6] = y[6] + (y[5] >>> 1);
        c[5] = y[5] - k4(c[6]);
        for (int i = 0; i < DCT_N; i++) d1[i*INT_W +: INT_W] = c[i];
    end

    idct_stage_reg #(.W(INT_W)) u_s1 (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_in(in_valid), .tag_in(row),
        .d(d1), .valid(v1), .tag(t1), .q(q1)
    );

    // I2: undo butterflies
    always_comb begin
        for (int i = 0; i < DCT_N; i++) p[i] = dct_int_t'(q1[i*INT_W +: INT_W]);
        b[0] = (p[0] + p[3]) >>> 1;
        b[3] = (p[0] - p[3]) >>> 1;
        b[1] = (p[1] + p[2]) >>> 1;
        b[2] = (p[1] - p[2]) >>> 1;
        b[4] = (p[4] + p[5]) >>> 1;
        b[5] = (p[4] - p[5]) >>> 1;
        b[7] = (p[7] + p[6]) >>> 1;
        b[6] = (p[7] - p[6]) >>> 1;
        for (int i = 0; i < DCT_N; i++) d2[i*INT_W +: INT_W] = b[i];
    end

    idct_stage_reg #(.W(INT_W)) u_s2 (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_in(v1), .tag_in(t1),
        .d(d2), .valid(v2), .tag(t2), .q(q2)
    );

    // I3: undo the lane 5/6 rotation lifting
    always_comb begin
        for (int i = 0; i < DCT_N; i++) s[i] = dct_int_t'(q2[i*INT_W +: INT_W]);
        a    = s;
        a[6] = s[6] - k2(s[5]);
        a[5] = k3(a[6]) - s[5];
        for (int i = 0; i < DCT_N; i++) d3[i*INT_W +: INT_W] = a[i];
    end

    idct_stage_reg #(.W(INT_W)) u_s3 (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_in(v2), .tag_in(t2),
        .d(d3), .valid(v3), .tag(t3), .q(q3)
    );

    // I4: undo forward stage 1, then format to 16 bits
    always_comb begin
        for (int i = 0; i < DCT_N; i++) u[i] = dct_int_t'(q3[i*INT_W +: INT_W]);
        for (int j = 0; j < DCT_N/2; j++) begin
            r[j]         = (u[j] + u[DCT_N-1-j]) >>> 1;
            r[DCT_N-1-j] = (u[j] - u[DCT_N-1-j]) >>> 1;
        end
        for (int i = 0; i < DCT_N; i++) d4[i*16 +: 16] = fmt(r[i]);
    end

    idct_stage_reg #(.W(16)) u_s4 (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_in(v3), .tag_in(t3),
        .d(d4), .valid(v4), .tag(t4), .q(x_out)
    );

    assign out_valid = v4;
    assign out_last  = v4 && (t4 == 3'd7);
endmodule

// File: tb/tb_idct_8pt_pipe.sv
// tb_idct_8pt_pipe: randomized self-checking bench for idct_8pt_pipe against an integer lifting model.
module tb_idct_8pt_pipe;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] y_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] x_out;
    logic         out_last;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nrow = 0;
    logic [127:0] exp_q[$];
    logic [127:0] got_q[$];
    bit           exp_l[$];
    bit           got_l[$];
    int           got_c[$];

    always #5 clk = ~clk;

    idct_8pt_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .y_in(y_in),
        .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out), .out_last(out_last)
    );

    function automatic int k2m(int v); return (v >>> 3) + (v >>> 2); endfunction
    function automatic int k3m(int v); return (v >>> 3) + (v >>> 1); endfunction
    function automatic int k4m(int v); return (v >>> 3) + (v >>> 2) + (v >>> 1); endfunction

    function automatic logic [15:0] fmt(int v);
`ifdef IDCT_CLAMP_EN
        return (v < 0) ? 16'd0 : (v > 255) ? 16'd255 : 16'(v);
`else
        return 16'(v);
`endif
    endfunction

    function automatic logic [127:0] pk(input int v[8]);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(v[i]);
        return r;
    endfunction

    // Golden inverse: the four lifting steps in plain integer arithmetic.
    function automatic logic [127:0] ref_idct(input logic [127:0] yv);
        int y[8], c[8], b[8], x[8];
        logic [127:0] r;
        for (int i = 0; i < 8; i++) y[i] = int'($signed(yv[i*16 +: 16]));
        c[1] = (y[0] >>> 1) - y[1]; c[0] = y[0] - c[1];
        c[3] = y[3] - k2m(y[2]);    c[2] = k2m(c[3]) - y[2];
        c[4] = y[4] + (y[7] >>> 3); c[7] = y[7];
        c[6] = y[6] + (y[5] >>> 1); c[5] = y[5] - k4m(c[6]);
        b[0] = (c[0] + c[3]) >>> 1; b[3] = (c[0] - c[3]) >>> 1;
        b[1] = (c[1] + c[2]) >>> 1; b[2] = (c[1] - c[2]) >>> 1;
        b[4] = (c[4] + c[5]) >>> 1; b[5] = (c[4] - c[5]) >>> 1;
        b[7] = (c[7] + c[6]) >>> 1; b[6] = (c[7] - c[6]) >>> 1;
        b[6] = b[6] - k2m(b[5]);
        b[5] = k3m(b[6]) - b[5];
        for (int j = 0; j < 4; j++) begin
            x[j]   = (b[j] + b[7-j]) >>> 1;
            x[7-j] = (b[j] - b[7-j]) >>> 1;
        end
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = fmt(x[i]);
        return r;
    endfunction

    // Team forward lifting DCT: exact inverse of the steps above.
    function automatic logic [127:0] fwd_dct(input int x[8]);
        int a[8], c[8], y[8];
        for (int j = 0; j < 4; j++) begin
            a[j]   = x[j] + x[7-j];
            a[7-j] = x[j] - x[7-j];
        end
        a[5] = k3m(a[6]) - a[5];
        a[6] = a[6] + k2m(a[5]);
        c[0] = a[0] + a[3]; c[3] = a[0] - a[3];
        c[1] = a[1] + a[2]; c[2] = a[1] - a[2];
        c[4] = a[4] + a[5]; c[5] = a[4] - a[5];
        c[7] = a[7] + a[6]; c[6] = a[7] - a[6];
        y[0] = c[0] + c[1]; y[1] = (y[0] >>> 1) - c[1];
        y[2] = k2m(c[3]) - c[2]; y[3] = c[3] + k2m(y[2]);
        y[7] = c[7]; y[4] = c[4] - (y[7] >>> 3);
        y[5] = c[5] + k4m(c[6]); y[6] = c[6] - (y[5] >>> 1);
        return pk(y);
    endfunction

    task automatic clear_q;
        exp_q.delete(); got_q.delete(); exp_l.delete(); got_l.delete(); got_c.delete();
    endtask

    task automatic step(input bit v, input logic [127:0] yv, input bit rdy);
        @(negedge clk);
        in_valid = v; y_in = yv; out_ready = rdy;
        #1;
        if (out_valid && out_ready) begin
            got_q.push_back(x_out); got_l.push_back(out_last); got_c.push_back(cyc);
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(ref_idct(y_in)); exp_l.push_back(nrow == 7);
            nrow = (nrow + 1) % 8;
        end
        cyc++;
    endtask

    task automatic drain;
        for (int t = 0; t < 60 && got_q.size() < exp_q.size(); t++) step(1'b0, '0, 1'b1);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL drain_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        nrow = 0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        if (x_out !== '0) begin failures++; $display("FAIL reset_x_out got=%h exp=0", x_out); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_dc;
        int dc[8] = '{16, 0, 0, 0, 0, 0, 0, 0};
        int start;
        do_reset();
        start = cyc;
        step(1'b1, pk(dc), 1'b1);
        drain();
        if (got_q.size() > 0) begin
            checks += 2;
            if (got_c[0] - start != 4) begin failures++; $display("FAIL dc_latency got=%0d exp=4", got_c[0] - start); end
            if (got_q[0] !== {8{16'd2}}) begin failures++; $display("FAIL dc_value got=%h exp=%h", got_q[0], {8{16'd2}}); end
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, '0, 1'b1);
        drain();
        for (int i = 0; i < got_q.size(); i++) begin
            checks += 3;
            if (got_q[i] !== '0) begin failures++; $display("FAIL b2b_data beat=%0d got=%h exp=0", i, got_q[i]); end
            if (got_l[i] !== (i == 7)) begin failures++; $display("FAIL b2b_last beat=%0d got=%b exp=%b", i, got_l[i], i == 7); end
            if (got_c[i] != got_c[0] + i) begin failures++; $display("FAIL b2b_gap beat=%0d got=%0d exp=%0d", i, got_c[i], got_c[0] + i); end
        end
    endtask

    task automatic test_clamp;
        int lo[8] = '{-64, 0, 0, 0, 0, 0, 0, 0};
        int hi[8] = '{4096, 0, 0, 0, 0, 0, 0, 0};
        logic [127:0] e_lo, e_hi;
`ifdef IDCT_CLAMP_EN
        e_lo = {8{16'd0}};
        e_hi = {8{16'd255}};
`else
        e_lo = {8{16'hFFF8}};
        e_hi = {8{16'd512}};
`endif
        do_reset();
        step(1'b1, pk(lo), 1'b1);
        step(1'b1, pk(hi), 1'b1);
        drain();
        if (got_q.size() == 2) begin
            checks += 2;
            if (got_q[0] !== e_lo) begin failures++; $display("FAIL clamp_neg got=%h exp=%h", got_q[0], e_lo); end
            if (got_q[1] !== e_hi) begin failures++; $display("FAIL clamp_big got=%h exp=%h", got_q[1], e_hi); end
        end
    endtask

    task automatic test_backpressure;
        int hold = 0;
        bit seen = 1'b0;
        bit rdy;
        logic [127:0] held = '0;
        int dc[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        do_reset();
        for (int t = 0; t < 60 && got_q.size() < 6; t++) begin
            dc[0] = 16 * (exp_q.size() + 1);
            rdy = (hold == 0);
            step(exp_q.size() < 6, pk(dc), rdy);
            if (!rdy) begin
                checks += 2;
                if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
                if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid got=%b exp=1", out_valid); end
                if (hold == 3) held = x_out;
                else begin
                    checks++;
                    if (x_out !== held) begin failures++; $display("FAIL bp_stable got=%h exp=%h", x_out, held); end
                end
                hold--;
            end
            if (!seen && got_q.size() == 1) begin seen = 1'b1; hold = 3; end
        end
        drain();
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== {8{16'(2 * (i + 1))}}) begin
                failures++; $display("FAIL bp_order beat=%0d got=%h exp=%h", i, got_q[i], {8{16'(2 * (i + 1))}});
            end
        end
    endtask

    task automatic test_round_trip;
        int x[8];
        logic [127:0] orig_q[$];
        logic [127:0] cur;
        bit v, r;
        int sent = 0;
        do_reset();
        for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(255));
        cur = fwd_dct(x);
        for (int t = 0; t < 5000 && sent < 256; t++) begin
            v = ($urandom_range(3) != 0);
            r = ($urandom_range(3) != 0);
            step(v, cur, r);
            if (exp_q.size() > sent) begin
                orig_q.push_back(pk(x));
                sent++;
                for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(255));
                cur = fwd_dct(x);
            end
        end
        for (int i = 0; i < 32; i++) begin
            for (int k = 0; k < 8; k++) x[k] = int'($urandom_range(4000)) - 2000;
            step(1'b1, pk(x), 1'b1);
        end
        drain();
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks += 2;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rt_model beat=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
            if (got_l[i] !== exp_l[i]) begin failures++; $display("FAIL rt_last beat=%0d got=%b exp=%b", i, got_l[i], exp_l[i]); end
            if (i < orig_q.size()) begin
                checks++;
                if (got_q[i] !== orig_q[i]) begin failures++; $display("FAIL rt_orig beat=%0d got=%h exp=%h", i, got_q[i], orig_q[i]); end
            end
        end
    endtask

    task automatic test_reset_mid;
        int x[8];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 8; k++) x[k] = int'($urandom_range(255));
            step(1'b1, fwd_dct(x), 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid got=%b exp=0", out_valid); end
        clear_q();
        nrow = 0;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 8; k++) x[k] = int'($urandom_range(255));
            step(1'b1, fwd_dct(x), 1'b1);
        end
        drain();
        for (int i = 0; i < got_q.size(); i++) begin
            checks += 2;
            if (got_l[i] !== (i == 7)) begin failures++; $display("FAIL mid_last beat=%0d got=%b exp=%b", i, got_l[i], i == 7); end
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL mid_data beat=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_dc();
        test_back_to_back();
        test_clamp();
        test_backpressure();
        test_round_trip();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/idct_8pt_pipe.md
# idct_8pt_pipe

Pipelined 8-point inverse of the team's shift-add lifting DCT. It takes one row or column of 16-bit signed coefficients per accepted beat and returns 8 reconstructed samples. It sits on the JPEG decode path after dequantisation; two instances around a transpose buffer form the 2-D IDCT. It uses a valid/ready handshake with full-pipeline stall and a 3-bit row counter that marks the last row of each 8x8 block.

## Interface
- `IN_W`, 16: coefficient width, signed.
- `INT_W`, 18: internal datapath width, signed. Inputs are sign-extended to this width.
- `OUT_W`, 8: unsigned sample width used by the clamp.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: `y_in` holds a valid row.
- `in_ready` output 1: the block accepts the row on this cycle.
- `y_in` input 8x`IN_W`: coefficients, index 0 = DC.
- `out_valid` output 1: `x_out` is valid.
- `out_ready` input 1: downstream accepts.
- `x_out` output 8x16 signed: reconstructed samples.
- `out_last` output 1: `x_out` carries row 7 of the current block.

## Operation
- Notation: `k2(v) = (v>>>3)+(v>>>2)`, `k3(v) = (v>>>3)+(v>>>1)`, `k4(v) = (v>>>3)+(v>>>2)+(v>>>1)`. All shifts are arithmetic and operate on `INT_W` values.
- Stage I1 undoes the forward stage 4:
  - `c1 = (y0>>>1) - y1`; `c0 = y0 - c1`
  - `c3 = y3 - k2(y2)`; `c2 = k2(c3) - y2`
  - `c4 = y4 + (y7>>>3)`; `c7 = y7`
  - `c6 = y6 + (y5>>>1)`; `c5 = y5 - k4(c6)`
- Stage I2 undoes the butterflies:
  - `b0 = (c0+c3)>>>1`, `b3 = (c0-c3)>>>1`
  - `b1 = (c1+c2)>>>1`, `b2 = (c1-c2)>>>1`
  - `b4 = (c4+c5)>>>1`, `b5 = (c4-c5)>>>1`
  - `b7 = (c7+c6)>>>1`, `b6 = (c7-c6)>>>1`
- Stage I3 undoes the forward stage 2: `a6 = b6 - k2(b5)`; `a5 = k3(a6) - b5`. All other lanes pass through.
- Stage I4 undoes the forward stage 1. For j = 0..3: `x[j] = (a[j]+a[7-j])>>>1` and `x[7-j] = (a[j]-a[7-j])>>>1`.
- The output is then formatted to 16 bits, with or without clamping (see Configuration).
- Row counter:
  - A 3-bit counter increments on every accepted input beat (`in_valid && in_ready`) and wraps from 7 to 0.
  - The value is captured alongside the data and pipelined with it.
  - `out_last` is asserted when the captured value equals 7.
- Each stage register has its own valid bit. Bubbles are carried through the pipeline and are not collapsed.

## Timing
- Latency: 4 cycles from an accepted input to `out_valid`, with one register per stage I1..I4. Throughput is 1 row/cycle while `out_ready` is high.
- Pipeline enable: `en = !out_valid || out_ready`. `in_ready = en`, with no combinational path from `in_valid`.
- While `en` is low, all stage registers, valid bits and the row counter hold their values. `x_out` stays stable while `out_valid && !out_ready`.
- Reset values: `out_valid` = 0, all stage valid bits = 0, row counter = 0, `x_out` = 0, `out_last` = 0.
- Reset mid-block: in-flight rows are discarded and counting restarts at row 0.
- Simultaneous accept and emit in the same cycle is legal. The pipeline advances with no lost or duplicated beats.
- Width rule: `INT_W` = 18 covers a full-scale 16-bit DC input without overflow. Truncation from 18 to 16 bits takes the low 16 bits unless clamping is enabled.

## Configuration
- `IDCT_CLAMP_EN` defined: the I4 result is saturated to [0, 2^`OUT_W`-1] and zero-extended to 16 bits.
- `IDCT_CLAMP_EN` undefined: `x_out` is the signed 18-bit result truncated to 16 bits, so negative values appear as negative numbers.
- Latency is identical in both builds.

## Structure
- Shared package `jpeg_dct_pkg` holds:
  - `dct_coef_t`, the signed `IN_W` coefficient type;
  - `dct_int_t`, the signed `INT_W` internal type;
  - `DCT_N` = 8;
  - functions `k2`, `k3` and `k4`, reused by the forward transform.
- Sub-module `idct_stage_reg`: a parameterised 8-lane register with a valid bit and enable, plus a 3-bit tag. It is instantiated four times.

## Test plan
- DC only: `y_in` = {16,0,0,0,0,0,0,0} -> after 4 cycles all `x_out` = 2.
- All-zero input -> all `x_out` = 0. Ten back-to-back rows give 10 consecutive output beats, with `out_last` on beats 8 only (beat 10 is row 1 of the next block).
- Clamp: `y0` = -64 -> all outputs = 0 with `IDCT_CLAMP_EN` and -8 without. `y0` = 4096 -> 255 with clamp and 512 without.
- Backpressure: stream 6 rows with distinct DC values, hold `out_ready` low for 3 cycles after the first output. Required:
  - `x_out` stays stable during the hold;
  - `in_ready` is 0 while stalled;
  - all 6 rows arrive in order, none lost or duplicated.
- Round-trip: run 256 random rows through the team's forward DCT model and then this block, and compare against the golden lifting-inverse model. The result must be bit-exact on every beat.
- Reset mid-stream: assert `rst_n` low for 1 cycle after row 3 has been accepted. Required:
  - `out_valid` = 0 on the next cycle;
  - the next block's 8th accepted row raises `out_last`.
